// File: rtl/wb_watchdog_pkg.sv
// Shared definitions for the wb_watchdog block: register map, CTRL/STATUS bit
// positions and the watchdog FSM state encoding.
package wb_watchdog_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_LOAD   = 3'd1;
    localparam logic [2:0] REG_WARN   = 3'd2;
    localparam logic [2:0] REG_KICK   = 3'd3;
    localparam logic [2:0] REG_COUNT  = 3'd4;
    localparam logic [2:0] REG_STATUS = 3'd5;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_LOCK   = 2;

    localparam int STAT_WARNED = 0;
    localparam int STAT_BADKEY = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIRE = 2'd2,
        ST_DONE = 2'd3
    } wdt_state_t;

endpackage

// File: rtl/wb_watchdog_regs.sv
// Wishbone classic slave front end for the watchdog: address decode, single-cycle
// registered ack, CTRL/LOAD/WARN/STATUS storage and the registered interrupt.
module wb_watchdog_regs
    import wb_watchdog_pkg::*;
#(
    parameter int            DW       = 32,
    parameter logic [DW-1:0] KICK_KEY = 32'h0000_C0DE,
    parameter logic [DW-1:0] LOAD_RST = 32'h00FF_FFFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    adr,
    input  logic [DW-1:0] dat_wr,
    input  logic          we,
    input  logic          cyc,
    input  logic          stb,
    output logic [DW-1:0] dat_rd,
    output logic          ack,
    input  logic [DW-1:0] count,
    input  logic          running,
    input  logic          warn_hit,
    output logic [DW-1:0] load,
    output logic [DW-1:0] warn,
    output logic          en_rise,
    output logic          en_clear,
    output logic          kick_good,
    output logic          kick_bad,
    output logic          irq
);

    logic [2:0]    sel;
    logic          access;
    logic          wr;
    logic          wr_ctrl;
    logic          wr_load;
    logic          wr_warn;
    logic          wr_kick;
    logic          wr_status;
    logic [2:0]    ctrl;
    logic [2:0]    ctrl_d;
    logic          warned;
    logic          warned_d;
    logic          badkey;
    logic          badkey_d;
    logic [DW-1:0] rdata;
    logic          unused_adr;

    assign sel        = adr[4:2];
    assign unused_adr = ^adr[1:0];
    assign access     = cyc & stb & ~ack;
    assign wr         = access & we;

    // LOCK freezes CTRL (including itself) and LOAD until the next bus reset
    assign wr_ctrl   = wr & (sel == REG_CTRL) & ~ctrl[CTRL_LOCK];
    assign wr_load   = wr & (sel == REG_LOAD) & ~ctrl[CTRL_LOCK];
    assign wr_warn   = wr & (sel == REG_WARN);
    assign wr_kick   = wr & (sel == REG_KICK);
    assign wr_status = wr & (sel == REG_STATUS);

    assign en_rise   = wr_ctrl & dat_wr[CTRL_EN] & ~ctrl[CTRL_EN];
    assign en_clear  = wr_ctrl & ~dat_wr[CTRL_EN];
    assign kick_good = wr_kick & (dat_wr == KICK_KEY);
    assign kick_bad  = wr_kick & (dat_wr != KICK_KEY);

    always_comb begin
        ctrl_d = ctrl;
        if (wr_ctrl) ctrl_d = dat_wr[2:0];
        // a new event wins over a coincident write-one-to-clear
        warned_d = (warned & ~(wr_status & dat_wr[STAT_WARNED])) | warn_hit;
        badkey_d = (badkey & ~(wr_status & dat_wr[STAT_BADKEY])) | (kick_bad & running);
    end

    always_comb begin
        rdata = '0;
        case (sel)
            REG_CTRL:   rdata = {{(DW-3){1'b0}}, ctrl};
            REG_LOAD:   rdata = load;
            REG_WARN:   rdata = warn;
            REG_COUNT:  rdata = count;
            REG_STATUS: rdata = {{(DW-2){1'b0}}, badkey, warned};
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack    <= 1'b0;
            dat_rd <= '0;
            ctrl   <= '0;
            load   <= LOAD_RST;
            warn   <= '0;
            warned <= 1'b0;
            badkey <= 1'b0;
            irq    <= 1'b0;
        end else begin
            ack    <= access;
            dat_rd <= (access & ~we) ? rdata : '0;
            ctrl   <= ctrl_d;
            if (wr_load) load <= dat_wr;
            if (wr_warn) warn <= dat_wr;
            warned <= warned_d;
            badkey <= badkey_d;
            irq    <= warned_d & ctrl_d[CTRL_IRQ_EN];
        end
    end

endmodule

// File: rtl/wb_watchdog.sv
// Wishbone watchdog timer: down-counter with key-word kick that raises a stretched
// reset request toward the system reset controller on expiry or a bad key.
//
// state | meaning
// IDLE  | disabled, COUNT held
// RUN   | COUNT decrements each clock, kicks reload it
// FIRE  | rst_req_o asserted for RST_PULSE clocks
// DONE  | request released, COUNT frozen until EN cleared or bus reset
module wb_watchdog
    import wb_watchdog_pkg::*;
#(
    parameter int            DW        = 32,
    parameter int            RST_PULSE = 16,
    parameter logic [DW-1:0] KICK_KEY  = 32'h0000_C0DE,
    parameter logic [DW-1:0] LOAD_RST  = 32'h00FF_FFFF
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [4:0]    wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    output logic [DW-1:0] wb_dat_o,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    output logic          wb_ack_o,
    output logic          irq_o,
    output logic          rst_req_o
);

    localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

    wdt_state_t    state;
    wdt_state_t    state_next;
    logic [DW-1:0] count;
    logic [DW-1:0] count_next;
    logic [PW-1:0] pulse;
    logic [PW-1:0] pulse_next;
    logic [DW-1:0] load;
    logic [DW-1:0] warn;
    logic [DW-1:0] reload;
    logic          en_rise;
    logic          en_clear;
    logic          kick_good;
    logic          kick_bad;
    logic          running;
    logic          warn_hit;

    assign running   = (state == ST_RUN);
    assign warn_hit  = running && (warn != '0) && (count == warn);
    assign reload    = (load == '0) ? {{(DW-1){1'b0}}, 1'b1} : load;
    assign rst_req_o = (state == ST_FIRE);

    wb_watchdog_regs #(
        .DW       (DW),
        .KICK_KEY (KICK_KEY),
        .LOAD_RST (LOAD_RST)
    ) u_regs (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .adr       (wb_adr_i),
        .dat_wr    (wb_dat_i),
        .we        (wb_we_i),
        .cyc       (wb_cyc_i),
        .stb       (wb_stb_i),
        .dat_rd    (wb_dat_o),
        .ack       (wb_ack_o),
        .count     (count),
        .running   (running),
        .warn_hit  (warn_hit),
        .load      (load),
        .warn      (warn),
        .en_rise   (en_rise),
        .en_clear  (en_clear),
        .kick_good (kick_good),
        .kick_bad  (kick_bad),
        .irq       (irq_o)
    );

    always_comb begin
        state_next = state;
        count_next = count;
        pulse_next = pulse;
        case (state)
            ST_IDLE: begin
                if (en_rise) begin
                    state_next = ST_RUN;
                    count_next = reload;
                end
            end
            ST_RUN: begin
                // a valid kick on the terminal-count cycle still reloads
                if (kick_bad) begin
                    state_next = ST_FIRE;
                    pulse_next = PW'(RST_PULSE - 1);
                end else if (kick_good) begin
                    count_next = reload;
                end else if (en_clear) begin
                    state_next = ST_IDLE;
                end else if (count == '0) begin
                    state_next = ST_FIRE;
                    pulse_next = PW'(RST_PULSE - 1);
                end else begin
                    count_next = count - 1'b1;
                end
            end
            ST_FIRE: begin
                if (pulse == '0) state_next = ST_DONE;
                else             pulse_next = pulse - 1'b1;
            end
            ST_DONE: begin
                if (en_clear) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
            count <= '0;
            pulse <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            pulse <= pulse_next;
        end
    end

endmodule
